// File: rtl/seg7_pkg.sv
// Purpose: shared types and segment-pattern constants for the 7-segment capture path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Patterns are active-low, bit0=a ... bit6=g, matching what the display
// driver puts on the pins.
package seg7_pkg;

  // Raw 7-bit segment pattern as seen on the bus.
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_0     = 7'h40;
  localparam seg7_t SEG7_1     = 7'h79;
  localparam seg7_t SEG7_2     = 7'h24;
  localparam seg7_t SEG7_3     = 7'h30;
  localparam seg7_t SEG7_4     = 7'h19;
  localparam seg7_t SEG7_5     = 7'h12;
  localparam seg7_t SEG7_6     = 7'h02;
  localparam seg7_t SEG7_7     = 7'h78;
  localparam seg7_t SEG7_8     = 7'h00;
  localparam seg7_t SEG7_9     = 7'h10;
  localparam seg7_t SEG7_A     = 7'h08;
  localparam seg7_t SEG7_B     = 7'h03;
  localparam seg7_t SEG7_C     = 7'h46;
  localparam seg7_t SEG7_D     = 7'h21;
  localparam seg7_t SEG7_E     = 7'h06;
  localparam seg7_t SEG7_F     = 7'h0E;
  localparam seg7_t SEG7_BLANK = 7'h7F;

  // Per-digit stability tracker states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no legal digit select on the bus
    ST_TRACK = 2'd1,  // counting identical samples of the current pair
    ST_HELD  = 2'd2   // current pair already committed, waiting for a change
  } cap_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Purpose: combinational segment pattern -> {hex nibble, blank, illegal}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   seg     : active-low segment pattern (bit0=a ... bit6=g)
//   nibble  : decoded hex value; forced to 0 for blank or illegal patterns
//   blank   : pattern is all segments off
//   illegal : pattern is neither a hex glyph nor blank
module seg7_decode
  import seg7_pkg::*;
(
  input  seg7_t      seg,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       illegal
);

  always_comb begin
    nibble  = 4'h0;
    blank   = 1'b0;
    illegal = 1'b0;
    case (seg)
      SEG7_0:     nibble = 4'h0;
      SEG7_1:     nibble = 4'h1;
      SEG7_2:     nibble = 4'h2;
      SEG7_3:     nibble = 4'h3;
      SEG7_4:     nibble = 4'h4;
      SEG7_5:     nibble = 4'h5;
      SEG7_6:     nibble = 4'h6;
      SEG7_7:     nibble = 4'h7;
      SEG7_8:     nibble = 4'h8;
      SEG7_9:     nibble = 4'h9;
      SEG7_A:     nibble = 4'hA;
      SEG7_B:     nibble = 4'hB;
      SEG7_C:     nibble = 4'hC;
      SEG7_D:     nibble = 4'hD;
      SEG7_E:     nibble = 4'hE;
      SEG7_F:     nibble = 4'hF;
      SEG7_BLANK: blank  = 1'b1;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Purpose: recover a multi-digit hex value from a multiplexed active-low 7-segment bus.
// Latency: a pair registered at edge 1 commits at edge STABLE_CYCLES+1; frame_valid follows that edge.
// Backpressure: none; the bus cannot be stalled, frames are simply overwritten by later ones.
//
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   seg          : active-low segment lines (bit0=a ... bit6=g)
//   an           : active-low digit selects, bit i = digit i (digit 0 = LS nibble)
//   value        : last complete frame, digit i in [4i+3:4i]
//   blank        : per-digit blank flags of the last frame
//   frame_valid  : one-cycle pulse whenever value/blank/frame_err load
//   frame_err    : last frame held at least one illegal pattern
//   err_count    : saturating illegal-commit counter
//
// Build option: define SEG7_CAPTURE_ERRCNT_EN to include the illegal-pattern
// counter; without it err_count is tied to zero.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic [7:0]              err_count
);

  // Count only has to reach STABLE_CYCLES.
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  // ---------------------------------------------------------------------------
  // Input stage: one register on the pins, plus the previous registered pair
  // so stability is judged sample-to-sample on registered data only.
  // ---------------------------------------------------------------------------
  seg7_t                 seg_q;
  seg7_t                 seg_p;
  logic [NUM_DIGITS-1:0] an_q;
  logic [NUM_DIGITS-1:0] an_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG7_BLANK;
      seg_p <= SEG7_BLANK;
      an_q  <= '1;
      an_p  <= '1;
    end else begin
      seg_q <= seg;
      seg_p <= seg_q;
      an_q  <= an;
      an_p  <= an_q;
    end
  end

  // Active-high select; legal only when exactly one bit is set.
  logic [NUM_DIGITS-1:0] sel_n;
  logic                  sel_valid;
  logic                  same_pair;

  assign sel_n     = ~an_q;
  assign sel_valid = (sel_n != '0) && ((sel_n & (sel_n - 1'b1)) == '0);
  assign same_pair = (an_q == an_p) && (seg_q == seg_p);

  // ---------------------------------------------------------------------------
  // Stability FSM
  // ---------------------------------------------------------------------------
  cap_state_t    state_q;
  cap_state_t    state_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] count_inc;
  logic          commit;

  assign count_inc = count_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    commit  = 1'b0;
    if (!sel_valid) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_TRACK: begin
          if (!same_pair) begin
            // New pair: this sample is the first of a fresh episode.
            if (STABLE_CYCLES == 1) begin
              commit  = 1'b1;
              state_d = ST_HELD;
              count_d = '0;
            end else begin
              state_d = ST_TRACK;
              count_d = CW'(1);
            end
          end else if (count_inc == CW'(STABLE_CYCLES)) begin
            commit  = 1'b1;
            state_d = ST_HELD;
            count_d = '0;
          end else begin
            count_d = count_inc;
          end
        end
        ST_HELD: begin
          // Unchanged pair stays here without re-committing.
          if (!same_pair) begin
            if (STABLE_CYCLES == 1) begin
              commit  = 1'b1;
              state_d = ST_HELD;
              count_d = '0;
            end else begin
              state_d = ST_TRACK;
              count_d = CW'(1);
            end
          end
        end
        default: begin
          // Coming from IDLE the previous sample had no legal select, so this
          // is always the first sample of an episode.
          if (STABLE_CYCLES == 1) begin
            commit  = 1'b1;
            state_d = ST_HELD;
            count_d = '0;
          end else begin
            state_d = ST_TRACK;
            count_d = CW'(1);
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Decode of the registered pattern
  // ---------------------------------------------------------------------------
  logic [3:0] dec_nibble;
  logic       dec_blank;
  logic       dec_illegal;

  seg7_decode u_decode (
    .seg     (seg_q),
    .nibble  (dec_nibble),
    .blank   (dec_blank),
    .illegal (dec_illegal)
  );

  // ---------------------------------------------------------------------------
  // Pending slots and frame assembly
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] slot_val_q;
  logic [4*NUM_DIGITS-1:0] slot_val_upd;
  logic [NUM_DIGITS-1:0]   slot_blank_q;
  logic [NUM_DIGITS-1:0]   slot_blank_upd;
  logic [NUM_DIGITS-1:0]   seen_q;
  logic                    pend_err_q;
  logic                    frame_done;

  // Pending slots with the current sample merged into the selected digit.
  // Only meaningful when commit is high (select is then one-hot).
  always_comb begin
    slot_val_upd   = slot_val_q;
    slot_blank_upd = slot_blank_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_n[i]) begin
        slot_val_upd[4*i +: 4] = dec_nibble;
        slot_blank_upd[i]      = dec_blank;
      end
    end
  end

  assign frame_done = &(seen_q | sel_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_val_q   <= '0;
      slot_blank_q <= '1;
      seen_q       <= '0;
      pend_err_q   <= 1'b0;
      value        <= '0;
      blank        <= '1;
      frame_err    <= 1'b0;
      frame_valid  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (commit) begin
        slot_val_q   <= slot_val_upd;
        slot_blank_q <= slot_blank_upd;
        if (frame_done) begin
          // Publish including this commit, then start a fresh frame.
          value       <= slot_val_upd;
          blank       <= slot_blank_upd;
          frame_err   <= pend_err_q | dec_illegal;
          frame_valid <= 1'b1;
          seen_q      <= '0;
          pend_err_q  <= 1'b0;
        end else begin
          seen_q     <= seen_q | sel_n;
          pend_err_q <= pend_err_q | dec_illegal;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Illegal-pattern counter
  // ---------------------------------------------------------------------------
`ifdef SEG7_CAPTURE_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (commit && dec_illegal && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

  localparam int ND = 4;
  localparam int SC = 4;
`ifdef SEG7_CAPTURE_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic [4*ND-1:0] value;
  logic [ND-1:0] blank;
  logic          frame_valid;
  logic          frame_err;
  logic [7:0]    err_count;

  always #5 clk = ~clk;

  seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .value       (value),
    .blank       (blank),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .err_count   (err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 60)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: run-length rule on the applied pin stream.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        fv;
    logic [15:0] value;
    logic [3:0]  blank;
    logic        err;
    logic [7:0]  ecnt;
  } exp_t;

  logic [6:0] pat_tbl [16];
  exp_t       cur, p0, p1, rst_exp;
  logic [3:0] last_an;
  logic [6:0] last_seg;
  int         run;
  logic [3:0] m_nib [4];
  logic [3:0] m_blank, m_seen;
  logic       m_perr;
  int         m_ecnt;

  task automatic ref_decode(input logic [6:0] p, output logic [3:0] nib,
                            output logic bl, output logic ill);
    nib = 4'h0; bl = 1'b0; ill = 1'b1;
    if (p == 7'h7F) begin
      bl = 1'b1; ill = 1'b0;
    end else begin
      for (int k = 0; k < 16; k++)
        if (pat_tbl[k] == p) begin nib = k[3:0]; ill = 1'b0; end
    end
  endtask

  task automatic model_reset();
    last_an = 4'hF; last_seg = 7'h7F; run = 0;
    m_seen = '0; m_perr = 1'b0; m_ecnt = 0; m_blank = '1;
    for (int k = 0; k < 4; k++) m_nib[k] = 4'h0;
    cur = rst_exp;
  endtask

  task automatic model_push(input logic [3:0] a, input logic [6:0] s, output exp_t e);
    logic valid;
    int d;
    logic [3:0] nib;
    logic bl, ill;
    valid = ($countones(~a) == 1);
    if (valid && run > 0 && a == last_an && s == last_seg) run++;
    else run = valid ? 1 : 0;
    last_an = a; last_seg = s;
    e = cur;
    if (valid && run == SC) begin
      d = 0;
      for (int k = 0; k < 4; k++) if (!a[k]) d = k;
      ref_decode(s, nib, bl, ill);
      m_nib[d] = nib; m_blank[d] = bl; m_seen[d] = 1'b1; m_perr = m_perr | ill;
      if (ill && m_ecnt < 255) m_ecnt++;
      cur.ecnt = ERRCNT ? m_ecnt[7:0] : 8'd0;
      e = cur;
      if (m_seen == 4'hF) begin
        cur.value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
        cur.blank = m_blank;
        cur.err   = m_perr;
        m_seen = '0; m_perr = 1'b0;
        e = cur;
        e.fv = 1'b1;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // One bench cycle: check outputs predicted two samples ago, then drive.
  // ---------------------------------------------------------------------------
  int          fv_cnt;
  logic [15:0] cap_value;
  logic [3:0]  cap_blank;
  logic        cap_err;

  task automatic cyc(input logic r, input logic [3:0] a, input logic [6:0] s);
    exp_t e;
    @(negedge clk);
    chk("frame_valid", frame_valid, p1.fv);
    chk("value", value, p1.value);
    chk("blank", blank, p1.blank);
    chk("frame_err", frame_err, p1.err);
    chk("err_count", err_count, p1.ecnt);
    if (frame_valid === 1'b1) begin
      fv_cnt++; cap_value = value; cap_blank = blank; cap_err = frame_err;
    end
    rst_n = r; an = a; seg = s;
    if (!r) begin
      model_reset();
      e = rst_exp;
      p0 = rst_exp;
    end else begin
      model_push(a, s, e);
    end
    p1 = p0;
    p0 = e;
  endtask

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] x;
    x = 4'hF;
    x[d] = 1'b0;
    return x;
  endfunction

  task automatic hold(input int d, input logic [6:0] s, input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, an_of(d), s);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 4'hF, 7'h7F);
  endtask

  // Hand-decoded frame vectors.
  typedef struct packed {
    logic [6:0]  s3, s2, s1, s0;
    logic [15:0] val;
    logic [3:0]  bl;
    logic        err;
    logic [7:0]  einc;
  } vec_t;

  vec_t vt [7];

  initial begin
    logic [7:0] e0;

    pat_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst_exp = '{fv: 1'b0, value: 16'h0, blank: 4'hF, err: 1'b0, ecnt: 8'd0};
    vt[0] = '{s3:7'h40, s2:7'h79, s1:7'h24, s0:7'h30, val:16'h0123, bl:4'b0000, err:1'b0, einc:8'd0};
    vt[1] = '{s3:7'h21, s2:7'h46, s1:7'h03, s0:7'h08, val:16'hDCBA, bl:4'b0000, err:1'b0, einc:8'd0};
    vt[2] = '{s3:7'h78, s2:7'h02, s1:7'h0E, s0:7'h06, val:16'h76FE, bl:4'b0000, err:1'b0, einc:8'd0};
    vt[3] = '{s3:7'h7F, s2:7'h00, s1:7'h7E, s0:7'h19, val:16'h0804, bl:4'b1000, err:1'b1, einc:8'd1};
    vt[4] = '{s3:7'h7F, s2:7'h7F, s1:7'h10, s0:7'h12, val:16'h0095, bl:4'b1100, err:1'b0, einc:8'd0};
    vt[5] = '{s3:7'h7F, s2:7'h7F, s1:7'h7F, s0:7'h7F, val:16'h0000, bl:4'b1111, err:1'b0, einc:8'd0};
    vt[6] = '{s3:7'h2A, s2:7'h55, s1:7'h01, s0:7'h7E, val:16'h0000, bl:4'b0000, err:1'b1, einc:8'd4};

    rst_n = 1'b0; an = 4'hF; seg = 7'h7F;
    model_reset();
    p0 = rst_exp; p1 = rst_exp;
    fv_cnt = 0; cap_value = '0; cap_blank = '0; cap_err = 1'b0;

    for (int k = 0; k < 3; k++) cyc(1'b0, 4'hF, 7'h7F);
    idle(2);
    chk("reset_value", value, 16'h0);
    chk("reset_blank", blank, 4'hF);
    chk("reset_frame_valid", frame_valid, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_err_count", err_count, 8'd0);

    // Table-driven full frames.
    for (int v = 0; v < 7; v++) begin
      fv_cnt = 0;
      e0 = err_count;
      hold(0, vt[v].s0, 6);
      hold(1, vt[v].s1, 6);
      hold(2, vt[v].s2, 6);
      hold(3, vt[v].s3, 6);
      idle(3);
      chk($sformatf("vec%0d_pulses", v), fv_cnt, 1);
      chk($sformatf("vec%0d_value", v), cap_value, vt[v].val);
      chk($sformatf("vec%0d_blank", v), cap_blank, vt[v].bl);
      chk($sformatf("vec%0d_err", v), cap_err, vt[v].err);
      chk($sformatf("vec%0d_errinc", v), 8'(err_count - e0), ERRCNT ? vt[v].einc : 8'd0);
    end

    // Glitch rejection: 5 shown for 3 cycles on digit 2 must never land.
    fv_cnt = 0;
    hold(0, 7'h40, 6);
    hold(1, 7'h79, 6);
    hold(2, 7'h12, 3);
    hold(2, 7'h02, 6);
    hold(3, 7'h24, 6);
    idle(3);
    chk("glitch_pulses", fv_cnt, 1);
    chk("glitch_value", cap_value, 16'h2610);

    // Recommit of a slot before completion: latest wins.
    fv_cnt = 0;
    hold(0, 7'h30, 6);
    hold(0, 7'h19, 6);
    hold(1, 7'h79, 6);
    hold(2, 7'h79, 6);
    hold(3, 7'h79, 6);
    idle(3);
    chk("recommit_pulses", fv_cnt, 1);
    chk("recommit_value", cap_value, 16'h1114);

    // Bad select: two selects low, then none; neither may commit.
    fv_cnt = 0;
    for (int k = 0; k < 10; k++) cyc(1'b1, 4'b0011, 7'h40);
    idle(10);
    hold(0, 7'h40, 6);
    hold(1, 7'h40, 6);
    hold(2, 7'h40, 6);
    idle(3);
    chk("badsel_no_frame", fv_cnt, 0);
    hold(3, 7'h79, 6);
    idle(3);
    chk("badsel_then_frame", fv_cnt, 1);
    chk("badsel_value", cap_value, 16'h1000);

    // Reset mid-frame discards partial slots.
    fv_cnt = 0;
    hold(0, 7'h30, 6);
    hold(1, 7'h30, 6);
    hold(2, 7'h30, 6);
    idle(1);
    cyc(1'b0, 4'hF, 7'h7F);
    cyc(1'b0, 4'hF, 7'h7F);
    hold(3, 7'h24, 6);
    idle(3);
    chk("midrst_no_frame", fv_cnt, 0);
    chk("midrst_value", value, 16'h0);
    chk("midrst_blank", blank, 4'hF);
    chk("midrst_err", frame_err, 1'b0);
    chk("midrst_err_count", err_count, 8'd0);
    hold(0, 7'h79, 6);
    hold(1, 7'h24, 6);
    hold(2, 7'h30, 6);
    idle(3);
    chk("midrst_recover", fv_cnt, 1);
    chk("midrst_recover_value", cap_value, 16'h2321);

    // Saturation: 300 illegal commits on digit 0.
    for (int k = 0; k < 300; k++) hold(0, (k % 2 == 0) ? 7'h7E : 7'h01, 5);
    idle(3);
    chk("saturation", err_count, ERRCNT ? 8'd255 : 8'd0);

    // Randomised episodes, checked cycle-by-cycle by the model.
    for (int ep = 0; ep < 400; ep++) begin
      logic [3:0] a;
      logic [6:0] s;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) a = 4'($urandom);
      else a = an_of($urandom_range(0, 3));
      r = $urandom_range(0, 15);
      if (r < 12) s = pat_tbl[$urandom_range(0, 15)];
      else if (r < 14) s = 7'h7F;
      else s = 7'($urandom);
      r = $urandom_range(1, 7);
      for (int k = 0; k < r; k++) cyc(1'b1, a, s);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Monitor-side receiver for the multiplexed, active-low 7-segment display bus. It samples the segment lines and the digit-select strobes, and waits until each digit's drive is stable. It then decodes each segment pattern back into a 4-bit hex nibble and assembles a full multi-digit value, reported with a one-cycle frame strobe. It sits on the display pins in self-checking boards and benches, closing the loop on the hex-to-segment encoding path.

## Interface
- `NUM_DIGITS`, default 4: number of multiplexed digits (1..8).
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a digit is committed (≥1).
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `seg` in 7: segment drive, active-low, bit0=a … bit6=g; synchronous to `clk`.
- `an` in NUM_DIGITS: digit select, active-low; bit i selects digit i (digit 0 = least-significant nibble).
- `value` out 4*NUM_DIGITS: last complete frame; digit i in bits [4i+3:4i].
- `blank` out NUM_DIGITS: bit i set if digit i was blank in the last frame (its nibble reads 0).
- `frame_valid` out 1: one-cycle pulse when `value`/`blank`/`frame_err` update.
- `frame_err` out 1: last frame contained at least one illegal pattern.
- `err_count` out 8: saturating illegal-pattern count (see Configuration).

## Operation
- Input stage: `seg` and `an` registered once; all logic works on registered copies.
- Select legality: exactly one `an` bit low means a valid select. Zero or multiple low bits mean no select: state returns to IDLE and nothing commits.
- States:
  - IDLE: no valid select. On a valid select, go to TRACK with count=1.
  - TRACK: on each cycle where the registered (`an`,`seg`) pair equals the previous one, count increments. Any change with a valid select restarts TRACK at count=1. When count==STABLE_CYCLES, commit and go to HELD.
  - HELD: the digit is already committed. Stay while the pair is unchanged. A change goes to TRACK (count=1) or IDLE. Exactly one commit per stable episode.
- Decode (active-low, hex):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9.
  - 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F.
  - 7F→blank.
  - Every other pattern is illegal.
- Commit on digit i:
  - Write the nibble to slot i, or 0 if blank/illegal.
  - Update the per-slot blank bit.
  - OR illegal into the pending error.
  - Set seen[i].
  - Recommitting a slot before the frame completes overwrites it (latest wins).
- Frame completion: when the commit makes seen all-ones, load `value`, `blank` and `frame_err` from the pending slots including this commit. Pulse `frame_valid`, then clear seen and the pending error.
- `STABLE_CYCLES`=1: commit on the first registered sample of each new pair.

## Timing
- Reset values: `value`=0, `blank`=all-ones, `frame_valid`=0, `frame_err`=0, `err_count`=0. Internal state: IDLE, seen=0.
- Reset mid-frame discards all partial slots; no `frame_valid` is generated from pre-reset commits.
- Latency: a pair present on the pins before edge 1 is registered at edge 1 (count=1) and commits at edge STABLE_CYCLES+1.
- If that commit completes the frame, `frame_valid` is high for exactly the cycle following that edge, and the outputs are valid in the same cycle.
- `frame_valid` never asserts on two consecutive cycles unless NUM_DIGITS=1 and STABLE_CYCLES=1.
- Outputs hold between frames.

## Configuration
- `SEG7_CAPTURE_ERRCNT_EN` defined: `err_count` increments on every illegal commit and saturates at 255. It is cleared only by reset.
- `SEG7_CAPTURE_ERRCNT_EN` undefined: the counter logic is absent and `err_count` is tied to 0. `frame_err` behaviour is unchanged.

## Structure
- Shared package `seg7_pkg` holds:
  - the 16 segment-pattern constants and `SEG7_BLANK`=7'h7F;
  - a typedef for the 7-bit pattern.
- Sub-module `seg7_decode`: combinational pattern → {nibble, blank, illegal}.
- Stability FSM, slot registers and frame logic live in `seg7_capture`.

## Test plan
- **Basic frame:** defaults; scan digits 0..3 with patterns 30,24,79,40 (digit i held 6 cycles each) → `frame_valid` pulses once, `value`=16'h0123, `blank`=0, `frame_err`=0.
- **Glitch rejection:** digit 2 shows 12 for 3 cycles, then 02 for 6 cycles → slot 2 reads 6. The 5 is never committed.
- **Blank/illegal:** digit 3 shows 7F, digit 1 shows 7E, others show legal patterns → `blank`=4'b1000, `frame_err`=1, nibbles 3 and 1 read 0. With the macro defined, `err_count`=1.
- **Bad select:** `an`=4'b0011 held for 10 cycles, then 4'b1111 for 10 cycles → no commit and no `frame_valid`.
- **Reset mid-frame:** commit digits 0..2, pulse `rst_n` low, then scan digit 3 only → no `frame_valid`, and all outputs at reset values.
- **Saturation:** with the macro defined, 300 illegal commits → `err_count`=255.
